// File: rtl/carfield_reg_demux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : carfield_reg_demux
// Brief    : Register-bus demultiplexer. Decodes the host address against an
//            address map, forwards the request to one slave and returns its
//            response. The optional slave-wait timeout is compiled in with the
//            macro CARFIELD_REG_DEMUX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module carfield_reg_demux #(
  parameter int unsigned NumSlv        = 4,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumSlv*AddrWidth-1:0]   map_start_i,
  input  logic [NumSlv*AddrWidth-1:0]   map_end_i,
  input  logic                          host_valid_i,
  input  logic                          host_write_i,
  input  logic [AddrWidth-1:0]          host_addr_i,
  input  logic [DataWidth-1:0]          host_wdata_i,
  input  logic [DataWidth/8-1:0]        host_wstrb_i,
  output logic                          host_ready_o,
  output logic [DataWidth-1:0]          host_rdata_o,
  output logic                          host_error_o,
  output logic [NumSlv-1:0]             slv_valid_o,
  output logic                          slv_write_o,
  output logic [AddrWidth-1:0]          slv_addr_o,
  output logic [DataWidth-1:0]          slv_wdata_o,
  output logic [DataWidth/8-1:0]        slv_wstrb_o,
  input  logic [NumSlv-1:0]             slv_ready_i,
  input  logic [NumSlv*DataWidth-1:0]   slv_rdata_i,
  input  logic [NumSlv-1:0]             slv_error_i,
  output logic                          busy_o,
  output logic [15:0]                   miss_cnt_o
);

  localparam int unsigned c_STRB_W = DataWidth / 8;
  localparam int unsigned c_IDX_W  = (NumSlv > 1) ? $clog2(NumSlv) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_FWD  = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [c_IDX_W-1:0]   r_idx;
  logic [AddrWidth-1:0] r_addr;
  logic                 r_write;
  logic [DataWidth-1:0] r_wdata;
  logic [c_STRB_W-1:0]  r_wstrb;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_error;
  logic [15:0]          r_miss_cnt;

  logic                 w_hit;
  logic [c_IDX_W-1:0]   w_hit_idx;
  logic                 w_sel_ready;
  logic [DataWidth-1:0] w_sel_rdata;
  logic                 w_sel_error;
  logic                 w_timeout;
  logic                 w_resp;

  // Descending scan so the lowest matching rule is the last one written.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NumSlv - 1; i >= 0; i--) begin
      if ((map_start_i[i*AddrWidth +: AddrWidth] <= host_addr_i) &&
          (host_addr_i < map_end_i[i*AddrWidth +: AddrWidth])) begin
        w_hit     = 1'b1;
        w_hit_idx = c_IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    w_sel_error = 1'b0;
    for (int i = 0; i < NumSlv; i++) begin
      if (r_idx == c_IDX_W'(i)) begin
        w_sel_ready = slv_ready_i[i];
        w_sel_rdata = slv_rdata_i[i*DataWidth +: DataWidth];
        w_sel_error = slv_error_i[i];
      end
    end
  end

`ifdef CARFIELD_REG_DEMUX_TIMEOUT_EN
  localparam int unsigned c_WAIT_W = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(TimeoutCycles);

  logic [c_WAIT_W-1:0] r_wait;
  logic [c_WAIT_W-1:0] w_wait_inc;

  assign w_wait_inc = r_wait + 1'b1;
  // Fires on the cycle the count would reach the limit, so valid stays up for exactly TimeoutCycles.
  assign w_timeout  = (r_state == c_FWD) && !w_sel_ready && (w_wait_inc == c_TIMEOUT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait <= '0;
    end else if (r_state == c_IDLE) begin
      r_wait <= '0;
    end else if ((r_state == c_FWD) && !w_sel_ready) begin
      r_wait <= w_wait_inc;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (host_valid_i) w_state_nxt = w_hit ? c_FWD : c_RESP;
      c_FWD:   if (w_sel_ready || w_timeout) w_state_nxt = c_RESP;
      c_RESP:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx      <= '0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rdata    <= '0;
      r_error    <= 1'b0;
      r_miss_cnt <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (host_valid_i) begin
            r_idx   <= w_hit_idx;
            r_addr  <= host_addr_i;
            r_write <= host_write_i;
            r_wdata <= host_wdata_i;
            r_wstrb <= host_wstrb_i;
            r_rdata <= '0;
            r_error <= !w_hit;
            if (!w_hit && (r_miss_cnt != 16'hFFFF)) begin
              r_miss_cnt <= r_miss_cnt + 16'd1;
            end
          end
        end
        c_FWD: begin
          if (w_sel_ready) begin
            r_rdata <= r_write ? '0 : w_sel_rdata;
            r_error <= w_sel_error;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_resp = (r_state == c_RESP);

  always_comb begin
    slv_valid_o = '0;
    for (int i = 0; i < NumSlv; i++) begin
      slv_valid_o[i] = (r_state == c_FWD) && (r_idx == c_IDX_W'(i));
    end
    host_ready_o = w_resp;
    host_rdata_o = w_resp ? r_rdata : '0;
    host_error_o = w_resp & r_error;
    busy_o       = (r_state != c_IDLE);
  end

  assign slv_write_o = r_write;
  assign slv_addr_o  = r_addr;
  assign slv_wdata_o = r_wdata;
  assign slv_wstrb_o = r_wstrb;
  assign miss_cnt_o  = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_carfield_reg_demux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_carfield_reg_demux
// Brief    : Self-checking bench for carfield_reg_demux (vector table plus
//            scoreboard, hand sequences for reset and slave-wait corners).
// Revision : 1.0 - initial release
// ============================================================================
module tb_carfield_reg_demux;

  localparam int NS = 4;
  localparam int AW = 48;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*AW-1:0]  map_start, map_end;
  logic              host_valid, host_write;
  logic [AW-1:0]     host_addr;
  logic [DW-1:0]     host_wdata;
  logic [SW-1:0]     host_wstrb;
  logic              host_ready;
  logic [DW-1:0]     host_rdata;
  logic              host_error;
  logic [NS-1:0]     slv_valid;
  logic              slv_write;
  logic [AW-1:0]     slv_addr;
  logic [DW-1:0]     slv_wdata;
  logic [SW-1:0]     slv_wstrb;
  logic [NS-1:0]     slv_ready;
  logic [NS*DW-1:0]  slv_rdata;
  logic [NS-1:0]     slv_error;
  logic              busy;
  logic [15:0]       miss_cnt;

  always #5 clk = ~clk;

  carfield_reg_demux #(
    .NumSlv(NS), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .map_start_i(map_start), .map_end_i(map_end),
    .host_valid_i(host_valid), .host_write_i(host_write), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_wstrb_i(host_wstrb),
    .host_ready_o(host_ready), .host_rdata_o(host_rdata), .host_error_o(host_error),
    .slv_valid_o(slv_valid), .slv_write_o(slv_write), .slv_addr_o(slv_addr),
    .slv_wdata_o(slv_wdata), .slv_wstrb_o(slv_wstrb),
    .slv_ready_i(slv_ready), .slv_rdata_i(slv_rdata), .slv_error_i(slv_error),
    .busy_o(busy), .miss_cnt_o(miss_cnt)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            k;
    logic [DW-1:0] srdata;
    bit            serr;
    int            exp_idx;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
    bit            scramble;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    bit            err;
    int            lat;
  } exp_t;

  exp_t sb[$];
  vec_t vt[10];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   miss_model = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Rule0 [0,0x2000), rule1 [0x0300_0000,0x0300_1000), rule2 [0x1000,0x4000), rule3 empty (start>end).
  task automatic set_map(input bit scramble);
    map_start = '0;
    map_end   = '0;
    if (!scramble) begin
      map_start[0*AW +: AW] = 48'h0;          map_end[0*AW +: AW] = 48'h2000;
      map_start[1*AW +: AW] = 48'h0300_0000;  map_end[1*AW +: AW] = 48'h0300_1000;
      map_start[2*AW +: AW] = 48'h1000;       map_end[2*AW +: AW] = 48'h4000;
      map_start[3*AW +: AW] = 48'h6000;       map_end[3*AW +: AW] = 48'h5000;
    end
  endtask

  // ready_at: FWD cycle at which the selected slave answers (0 = never).
  task automatic run_txn(input vec_t v, input int lat, input int ready_at, input string tag);
    logic [NS-1:0] oh;
    logic [NS-1:0] exp_valid;
    exp_t e;
    bit   hit;
    bit   done;
    hit  = (v.exp_idx >= 0);
    done = 1'b0;
    oh   = '0;
    if (hit) oh[v.exp_idx] = 1'b1;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.lat   = lat;
    sb.push_back(e);
    if (!hit && miss_model < 16'hFFFF) miss_model++;

    @(negedge clk);
    host_valid = 1'b1;
    host_write = v.wr;
    host_addr  = v.addr;
    host_wdata = v.wdata;
    host_wstrb = v.wstrb;
    for (int c = 0; c <= lat + 2 && !done; c++) begin
      if (c > 0) @(negedge clk);
      set_map(v.scramble && c >= 1 && c <= lat);
      // Non-selected ports always claim ready with junk data; only the selected one matters.
      slv_ready = (hit && ready_at > 0 && c == ready_at) ? '1 : ~oh;
      for (int i = 0; i < NS; i++) begin
        slv_rdata[i*DW +: DW] = (i == v.exp_idx) ? v.srdata : (32'hDEAD_0000 | i);
        slv_error[i]          = (i == v.exp_idx) ? v.serr : 1'b1;
      end
      #1;
      exp_valid = (hit && c >= 1 && c < lat) ? oh : '0;
      check($sformatf("%s.slv_valid@%0d", tag, c), 64'(slv_valid), 64'(exp_valid));
      check($sformatf("%s.busy@%0d", tag, c), 64'(busy), 64'(c >= 1));
      if (hit && c == 1) begin
        check($sformatf("%s.slv_req", tag),
              {slv_addr[31:0], slv_wdata[27:0], slv_wstrb, 64'(0)} >> 64,
              {v.addr[31:0], v.wdata[27:0], v.wstrb, 64'(0)} >> 64);
        check($sformatf("%s.slv_write", tag), 64'(slv_write), 64'(v.wr));
      end
      if (host_ready) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          check($sformatf("%s.unexpected_resp", tag), 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check($sformatf("%s.latency", tag), 64'(c), 64'(e.lat));
          check($sformatf("%s.rdata", tag), 64'(host_rdata), 64'(e.rdata));
          check($sformatf("%s.error", tag), 64'(host_error), 64'(e.err));
          check($sformatf("%s.miss_cnt", tag), 64'(miss_cnt), 64'(miss_model));
        end
      end else begin
        check($sformatf("%s.idle_resp@%0d", tag, c), {host_rdata, 31'(0), host_error}, 64'(0));
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s.timeout: actual=no_response required=response_at_cycle_%0d", tag, lat);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(negedge clk);
    host_valid = 1'b0;
    slv_ready  = '0;
    set_map(1'b0);
    #1;
    check($sformatf("%s.after_ready", tag), {host_ready, busy}, 64'(0));
  endtask

  // Starts a read to rule1 whose slave never answers, leaving the DUT waiting in FWD.
  task automatic start_stuck_read(input logic [AW-1:0] addr);
    @(negedge clk);
    host_valid = 1'b1;
    host_write = 1'b0;
    host_addr  = addr;
    slv_ready  = '0;
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    host_valid = 1'b0;
    #1;
    check($sformatf("%s.valid_async", tag), 64'(slv_valid), 64'(0));
    check($sformatf("%s.busy_async", tag), 64'(busy), 64'(0));
    check($sformatf("%s.ready_async", tag), 64'(host_ready), 64'(0));
    check($sformatf("%s.miss_async", tag), 64'(miss_cnt), 64'(0));
    miss_model = 0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{wr:0, addr:48'h0300_0004, wdata:0, wstrb:0, k:1, srdata:32'hCAFE_F00D, serr:0,
              exp_idx:1, exp_rdata:32'hCAFE_F00D, exp_err:0, scramble:0};
    vt[1] = '{wr:0, addr:48'h0400_0000, wdata:0, wstrb:0, k:0, srdata:32'h1111_1111, serr:0,
              exp_idx:-1, exp_rdata:0, exp_err:1, scramble:0};
    vt[2] = '{wr:0, addr:48'h1000, wdata:0, wstrb:0, k:2, srdata:32'h1111_2222, serr:0,
              exp_idx:0, exp_rdata:32'h1111_2222, exp_err:0, scramble:0};
    vt[3] = '{wr:0, addr:48'h0300_1000, wdata:0, wstrb:0, k:0, srdata:0, serr:0,
              exp_idx:-1, exp_rdata:0, exp_err:1, scramble:0};
    vt[4] = '{wr:0, addr:48'h0300_0000, wdata:0, wstrb:0, k:1, srdata:32'hA5A5_0001, serr:0,
              exp_idx:1, exp_rdata:32'hA5A5_0001, exp_err:0, scramble:0};
    vt[5] = '{wr:1, addr:48'h0300_0010, wdata:32'h1234_5678, wstrb:4'hF, k:5, srdata:32'hFFFF_FFFF, serr:1,
              exp_idx:1, exp_rdata:0, exp_err:1, scramble:0};
    vt[6] = '{wr:0, addr:48'h3000, wdata:0, wstrb:0, k:3, srdata:32'h0BAD_BEEF, serr:0,
              exp_idx:2, exp_rdata:32'h0BAD_BEEF, exp_err:0, scramble:0};
    vt[7] = '{wr:0, addr:48'h5800, wdata:0, wstrb:0, k:0, srdata:0, serr:0,
              exp_idx:-1, exp_rdata:0, exp_err:1, scramble:0};
    vt[8] = '{wr:0, addr:48'h0300_0020, wdata:0, wstrb:0, k:3, srdata:32'h7777_8888, serr:1,
              exp_idx:1, exp_rdata:32'h7777_8888, exp_err:1, scramble:1};
    vt[9] = '{wr:1, addr:48'h10, wdata:32'h0000_ABCD, wstrb:4'h3, k:1, srdata:32'h5555_5555, serr:0,
              exp_idx:0, exp_rdata:0, exp_err:0, scramble:0};

    rst        = 1'b1;
    host_valid = 1'b0;
    host_write = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    host_wstrb = '0;
    slv_ready  = '0;
    slv_rdata  = '0;
    slv_error  = '0;
    set_map(1'b0);
    #1;
    check("reset.outputs", {host_ready, host_error, busy, slv_valid, miss_cnt}, 64'(0));
    check("reset.rdata", 64'(host_rdata), 64'(0));
    check("reset.req_regs", {slv_write, slv_wstrb, slv_addr[31:0]}, 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 10; n++) begin
      run_txn(vt[n], (vt[n].exp_idx < 0) ? 1 : vt[n].k + 1, vt[n].k, $sformatf("vec%0d", n));
    end

    // Reset while the slave is still pending, then a normal transfer must complete.
    start_stuck_read(48'h0300_0008);
    repeat (3) @(negedge clk);
    #1;
    check("rst_mid.valid_before", 64'(slv_valid), 64'h2);
    async_reset("rst_mid");
    run_txn(vt[0], 2, 1, "post_rst");

`ifdef CARFIELD_REG_DEMUX_TIMEOUT_EN
    run_txn('{wr:0, addr:48'h0300_0040, wdata:0, wstrb:0, k:0, srdata:32'h9999_9999, serr:0,
              exp_idx:1, exp_rdata:0, exp_err:1, scramble:0}, TO + 1, 0, "timeout");
`else
    start_stuck_read(48'h0300_0040);
    repeat (40) @(negedge clk);
    #1;
    check("hang.busy", 64'(busy), 64'(1));
    check("hang.valid", 64'(slv_valid), 64'h2);
    check("hang.no_ready", 64'(host_ready), 64'(0));
    async_reset("hang");
`endif

    run_txn(vt[1], 1, 0, "final_miss");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/carfield_reg_demux.md
CARFIELD_REG_DEMUX -- requirements
Module: carfield_reg_demux

Interface
REQ-001 SHALL have parameter NumSlv, default 4: number of register-bus slave ports; legal range 1..16.
REQ-002 SHALL have parameter AddrWidth, default 48: request address width.
REQ-003 SHALL have parameter DataWidth, default 32: data width; strobe width is DataWidth/8.
REQ-004 SHALL have parameter TimeoutCycles, default 255: slave-wait limit, used only when the timeout feature is compiled in.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk_i in 1 (system clock); rst_i in 1 (async active-high reset).
REQ-006 SHALL have the address-map input: map_start_i in NumSlv*AddrWidth (per-rule inclusive start); map_end_i in NumSlv*AddrWidth (per-rule exclusive end).
REQ-007 SHALL have the host request inputs: host_valid_i in 1; host_write_i in 1; host_addr_i in AddrWidth; host_wdata_i in DataWidth; host_wstrb_i in DataWidth/8.
REQ-008 SHALL have the host response outputs: host_ready_o out 1; host_rdata_o out DataWidth; host_error_o out 1.
REQ-009 SHALL have the slave request outputs, shared by all slaves: slv_valid_o out NumSlv; slv_write_o out 1; slv_addr_o out AddrWidth; slv_wdata_o out DataWidth; slv_wstrb_o out DataWidth/8.
REQ-010 SHALL have the slave response inputs: slv_ready_i in NumSlv; slv_rdata_i in NumSlv*DataWidth; slv_error_i in NumSlv.
REQ-011 SHALL have the status outputs: busy_o out 1 (high when not IDLE); miss_cnt_o out 16 (saturating decode-miss counter).

Function
REQ-012 SHALL implement an FSM with states IDLE, FWD and RESP.
REQ-013 SHALL, in IDLE with host_valid_i=1, register addr, write, wdata and wstrb, plus the decoded index, within the same cycle.
REQ-014 SHALL decode as a hit on rule i when map_start_i[i] <= addr < map_end_i[i]; the lowest matching index wins; a rule with start >= end never matches.
REQ-015 SHALL, on a hit, go IDLE->FWD; in FWD, drive slv_valid_o one-hot at the registered index, with request fields from the registers.
REQ-016 SHALL, in FWD, when slv_ready_i[idx]=1, capture slv_rdata_i[idx] and slv_error_i[idx], drop slv_valid_o the same cycle, and go to RESP.
REQ-017 SHALL, on a miss, go IDLE->RESP with error=1 and rdata=0; miss_cnt_o increments by 1 and saturates at 16'hFFFF.
REQ-018 SHALL, in RESP, assert host_ready_o for exactly one cycle with the captured rdata and error, then return to IDLE.
REQ-019 SHALL give hit latency as: valid seen at cycle 0 and slave ready at FWD cycle k (k>=1) -> host_ready_o at cycle k+1; with zero slave wait, host_ready_o is at cycle 2.
REQ-020 SHALL give miss latency as host_ready_o at cycle 1.
REQ-021 SHALL keep host_ready_o=0 outside RESP; host_rdata_o and host_error_o are 0 outside RESP.
REQ-022 SHALL ignore host_valid_i outside IDLE; the host holds its request until host_ready_o.
REQ-023 SHALL ignore slv_ready_i on non-selected ports, and in IDLE and RESP.
REQ-024 SHALL register write responses with rdata forced to 0.
REQ-025 SHALL sample map_start_i and map_end_i only in IDLE at acceptance; map changes during FWD or RESP do not affect the transfer in flight.

Reset
REQ-026 SHALL, on assertion of rst_i, immediately set FSM=IDLE, slv_valid_o=0, host_ready_o=0, host_rdata_o=0, host_error_o=0, busy_o=0, miss_cnt_o=0, and clear all request registers.
REQ-027 SHALL, on reset asserted mid-FWD, abandon the transfer with no response to the host; the first acceptance is possible on the first clock edge after rst_i deasserts.

Configuration
REQ-028 SHALL, with macro CARFIELD_REG_DEMUX_TIMEOUT_EN defined, implement a wait counter: cleared on FWD entry, incremented each FWD cycle without ready; when it reaches TimeoutCycles, drop slv_valid_o and go to RESP with error=1 and rdata=0.
REQ-029 SHALL, with CARFIELD_REG_DEMUX_TIMEOUT_EN undefined, have no counter: FWD waits indefinitely for ready and TimeoutCycles is unused.

Verification
REQ-030 SHALL cover a read hit: map rule1=[0x0300_0000,0x0300_1000), read addr 0x0300_0004, slave1 ready at once with rdata 0xCAFE_F00D -> slv_valid_o=4'b0010 at cycle 1; host_ready_o at cycle 2 with 0xCAFE_F00D and error=0.
REQ-031 SHALL cover a miss: read addr 0x0400_0000 with no rule matching -> host_ready_o at cycle 1, error=1, rdata=0, miss_cnt_o=1, no slv_valid_o ever high.
REQ-032 SHALL cover overlap and boundaries: rules 0 and 2 both cover 0x1000 -> port 0 selected; addr equal to end 0x0300_1000 -> miss; addr equal to start 0x0300_0000 -> hit.
REQ-033 SHALL cover a write with wait: write 0x1234_5678, wstrb 4'hF; slave ready after 5 FWD cycles with error=1 -> slv_valid_o held for 5 cycles, host_ready_o at cycle 6, error=1, rdata=0.
REQ-034 SHALL cover the timeout, with the macro defined and TimeoutCycles=8, slave never ready -> slv_valid_o high for 8 cycles, then host_ready_o with error=1; with the macro undefined -> busy_o stays high indefinitely.
REQ-035 SHALL cover reset mid-FWD: assert rst_i during slave wait -> slv_valid_o and busy_o go to 0 asynchronously; the next request after deassertion completes normally.
